// File: rtl/param_bcd_formatter.sv
`default_nettype none
// ============================================================================
// Module   : param_bcd_formatter
// Purpose  : Converts four 16-bit measurements (frequency, amplitude, duty,
//            THD) into five-digit BCD using a sequential double-dabble engine.
//            Duty and THD saturate at CLAMP_PERMILLE.
// Revision : 1.0 - initial release
// ============================================================================
module param_bcd_formatter #(
  parameter int CLAMP_PERMILLE = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] freq_in,
  input  logic [15:0] amplitude_in,
  input  logic [15:0] duty_in,
  input  logic [15:0] thd_in,
  output logic [19:0] bcd_freq,
  output logic [19:0] bcd_amp,
  output logic [19:0] bcd_duty,
  output logic [19:0] bcd_thd,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] CLAMP_VAL =
    (CLAMP_PERMILLE > 65535) ? 16'hFFFF : 16'(CLAMP_PERMILLE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_hold [4];
  logic [15:0] r_shift;
  logic [19:0] r_acc;
  logic [3:0]  r_bitcnt;
  logic [1:0]  r_index;
  logic [19:0] r_sh_freq;
  logic [19:0] r_sh_amp;
  logic [19:0] r_sh_duty;

  logic [15:0] w_duty_clamped;
  logic [15:0] w_thd_clamped;
  logic [15:0] w_adj;

  assign w_duty_clamped = (duty_in > CLAMP_VAL) ? CLAMP_VAL : duty_in;
  assign w_thd_clamped  = (thd_in  > CLAMP_VAL) ? CLAMP_VAL : thd_in;

  // Add-3 correction on the lower four digits. The top digit never reaches 5
  // before a shift for a 16-bit source (at most 3 before the last shift), so
  // it passes through uncorrected.
  generate
    for (genvar g = 0; g < 4; g++) begin : g_adjust
      assign w_adj[4*g +: 4] = (r_acc[4*g +: 4] >= 4'd5) ?
                               r_acc[4*g +: 4] + 4'd3 : r_acc[4*g +: 4];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and status outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_LOAD;
      end
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (r_bitcnt == 4'd15) w_next = S_STORE;
      S_STORE: w_next = (r_index == 2'd3) ? S_DONE : S_LOAD;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Snapshot, conversion datapath, shadow results and atomic output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold[0] <= '0;
      r_hold[1] <= '0;
      r_hold[2] <= '0;
      r_hold[3] <= '0;
      r_shift   <= '0;
      r_acc     <= '0;
      r_bitcnt  <= '0;
      r_index   <= '0;
      r_sh_freq <= '0;
      r_sh_amp  <= '0;
      r_sh_duty <= '0;
      bcd_freq  <= '0;
      bcd_amp   <= '0;
      bcd_duty  <= '0;
      bcd_thd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_hold[0] <= freq_in;
            r_hold[1] <= amplitude_in;
            r_hold[2] <= w_duty_clamped;
            r_hold[3] <= w_thd_clamped;
            r_index   <= 2'd0;
          end
        end
        S_LOAD: begin
          r_shift  <= r_hold[r_index];
          r_acc    <= '0;
          r_bitcnt <= '0;
        end
        S_SHIFT: begin
          r_acc    <= {r_acc[18:16], w_adj, r_shift[15]};
          r_shift  <= {r_shift[14:0], 1'b0};
          r_bitcnt <= r_bitcnt + 4'd1;
        end
        S_STORE: begin
          case (r_index)
            2'd0: r_sh_freq <= r_acc;
            2'd1: r_sh_amp  <= r_acc;
            2'd2: r_sh_duty <= r_acc;
            default: begin
              // Last parameter goes straight out alongside the shadows so
              // all four outputs update on the edge entering DONE.
              bcd_freq <= r_sh_freq;
              bcd_amp  <= r_sh_amp;
              bcd_duty <= r_sh_duty;
              bcd_thd  <= r_acc;
            end
          endcase
          if (r_index != 2'd3) r_index <= r_index + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_bcd_formatter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_bcd_formatter
// Purpose  : Scoreboard bench for param_bcd_formatter; directed scenarios plus
//            randomized conversions against an arithmetic decimal model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_bcd_formatter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] freq_in = '0, amplitude_in = '0, duty_in = '0, thd_in = '0;
  logic [19:0] bcd_freq, bcd_amp, bcd_duty, bcd_thd;
  logic        busy, done;

  param_bcd_formatter #(.CLAMP_PERMILLE(1000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .freq_in(freq_in), .amplitude_in(amplitude_in),
    .duty_in(duty_in), .thd_in(thd_in),
    .bcd_freq(bcd_freq), .bcd_amp(bcd_amp),
    .bcd_duty(bcd_duty), .bcd_thd(bcd_thd),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] f, a, d, t;
    int          due;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal digits by plain division
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int          x;
    r = '0;
    x = v;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clamp(input int v);
    return (v > 1000) ? 1000 : v;
  endfunction

  function automatic exp_t model(input int f, input int a, input int d, input int t, input int due);
    exp_t e;
    e.f = to_bcd(f);
    e.a = to_bcd(a);
    e.d = to_bcd(clamp(d));
    e.t = to_bcd(clamp(t));
    e.due = due;
    return e;
  endfunction

  // Monitor: checks every done against the scoreboard and output stability
  logic [79:0] prev_out = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.due));
          check("bcd_freq", 32'(bcd_freq), 32'(e.f));
          check("bcd_amp",  32'(bcd_amp),  32'(e.a));
          check("bcd_duty", 32'(bcd_duty), 32'(e.d));
          check("bcd_thd",  32'(bcd_thd),  32'(e.t));
        end
      end else if ({bcd_freq, bcd_amp, bcd_duty, bcd_thd} !== prev_out) begin
        check("outputs_stable", 32'd1, 32'd0);
      end
    end
    prev_out = {bcd_freq, bcd_amp, bcd_duty, bcd_thd};
  end

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issues one start pulse from IDLE; returns the cycle done is expected in
  task automatic issue(input int f, input int a, input int d, input int t, output int due);
    wait_idle();
    freq_in = 16'(f); amplitude_in = 16'(a); duty_in = 16'(d); thd_in = 16'(t);
    start = 1'b1;
    due = cyc + 73;
    q.push_back(model(f, a, d, t, due));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_freq"}, 32'(bcd_freq), 32'd0);
    check({tag, "_amp"},  32'(bcd_amp),  32'd0);
    check({tag, "_duty"}, 32'(bcd_duty), 32'd0);
    check({tag, "_thd"},  32'(bcd_thd),  32'd0);
  endtask

  initial begin
    int due;
    int c0;
    int n;
    logic busy_ok;
    int sweep [$];

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic conversion and clamping/boundary values
    issue(1234, 200, 500, 37, due);
    issue(65535, 0, 1500, 1000, due);
    issue(0, 65535, 65535, 1001, due);

    // Start and input change while busy are ignored
    issue(4321, 77, 999, 5, due);
    c0 = due - 73;
    while (cyc < c0 + 10) @(negedge clk);
    freq_in = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_ok = 1'b1;
    while (cyc < c0 + 72) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
    check("busy_held", 32'(busy_ok), 32'd1);
    repeat (100) @(negedge clk);

    // Start held high: back-to-back conversions every 74 cycles
    wait_idle();
    freq_in = 16'd808; amplitude_in = 16'd4095; duty_in = 16'd250; thd_in = 16'd2000;
    start = 1'b1;
    c0 = cyc;
    q.push_back(model(808, 4095, 250, 2000, c0 + 73));
    q.push_back(model(808, 4095, 250, 2000, c0 + 147));
    q.push_back(model(808, 4095, 250, 2000, c0 + 221));
    repeat (200) @(negedge clk);
    start = 1'b0;

    // Reset in the middle of a conversion
    issue(11111, 22222, 333, 444, due);
    c0 = due - 73;
    while (cyc < c0 + 30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(54321, 12, 1000, 0, due);

    // Frequency sweep sample including decade edges
    sweep = '{0, 9, 10, 99, 100, 999, 1000, 4567, 9998, 9999, 10000, 59999, 65535};
    foreach (sweep[i]) issue(sweep[i], sweep[i] % 1001, 1000 - (sweep[i] % 1001), 7, due);

    // Randomized conversions
    for (int i = 0; i < 30; i++)
      issue(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
            int'($urandom_range(0, 1500)), int'($urandom_range(0, 1500)), due);

    // Drain the scoreboard
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
